// File: rtl/denorm_unit.sv
// Iterative mantissa right-shifter with early exit and an optional sticky bit.
// Define DENORM_STICKY_EN to build the sticky flop; otherwise sticky is tied low.
module denorm_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  shift_in,
    output logic              rdy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              sticky
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] r1;
    logic [CNT_W-1:0]  r2;
    logic              accept;

    function automatic logic [DATA_W-1:0] shr1(input logic [DATA_W-1:0] v);
        return v >> 1;
    endfunction

    assign accept   = (state == S_IDLE) && start;
    assign rdy      = (state == S_IDLE);
    assign done     = (state == S_DONE);
    assign data_out = r1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            // Early exit keeps R2 from ever counting below zero.
            S_CHECK: state_nxt = (r2 == '0 || r1 == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: state_nxt = S_CHECK;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r1 <= '0;
            r2 <= '0;
        end else if (accept) begin
            r1 <= data_in;
            r2 <= shift_in;
        end else if (state == S_SHIFT) begin
            r1 <= shr1(r1);
            r2 <= r2 - CNT_W'(1);
        end
    end

`ifdef DENORM_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                   sticky_q <= 1'b0;
        else if (accept)             sticky_q <= 1'b0;
        else if (state == S_SHIFT)   sticky_q <= sticky_q | r1[0];
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_denorm_unit.sv
// Directed testbench for denorm_unit (8-bit mantissa, 4-bit shift count).
module tb_denorm_unit;

`ifdef DENORM_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk;
    logic       rstb;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] shift_in;
    logic       rdy;
    logic       done;
    logic [7:0] data_out;
    logic       sticky;

    int pass_cnt  = 0;
    int total_cnt = 0;

    denorm_unit #(.DATA_W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .start    (start),
        .data_in  (data_in),
        .shift_in (shift_in),
        .rdy      (rdy),
        .done     (done),
        .data_out (data_out),
        .sticky   (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request at a negedge; returns at the negedge after the accept edge E0.
    task automatic start_op(input logic [7:0] d, input logic [3:0] s);
        @(negedge clk);
        data_in  = d;
        shift_in = s;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges after E0 until done is seen; bounded at 40.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; start = 1'b0; data_in = 8'h00; shift_in = 4'h0;
        #1;
        total_cnt++; if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", rdy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_out); else pass_cnt++;
        total_cnt++; if (sticky !== 1'b0) $display("FAIL reset_sticky: got %b expected 0", sticky); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_op(input string nm, input logic [7:0] d, input logic [3:0] s,
                           input logic [7:0] exp_d, input logic exp_s, input int exp_n);
        int n;
        @(negedge clk);
        total_cnt++; if (rdy !== 1'b1) $display("FAIL %s_rdy_before: got %b expected 1", nm, rdy); else pass_cnt++;
        start_op(d, s);
        total_cnt++; if (rdy !== 1'b0) $display("FAIL %s_busy: got rdy %b expected 0", nm, rdy); else pass_cnt++;
        wait_done(n);
        total_cnt++; if (n !== exp_n) $display("FAIL %s_latency: got %0d expected %0d", nm, n, exp_n); else pass_cnt++;
        total_cnt++; if (data_out !== exp_d) $display("FAIL %s_data: got %h expected %h", nm, data_out, exp_d); else pass_cnt++;
        total_cnt++; if (sticky !== (exp_s & STK)) $display("FAIL %s_sticky: got %b expected %b", nm, sticky, exp_s & STK); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0 || rdy !== 1'b1) $display("FAIL %s_after: got done %b rdy %b expected 0 1", nm, done, rdy); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (data_out !== exp_d || sticky !== (exp_s & STK)) $display("FAIL %s_hold: got %h/%b expected %h/%b", nm, data_out, sticky, exp_d, exp_s & STK); else pass_cnt++;
    endtask

    task automatic test_ignore_and_back_to_back();
        int n;
        start_op(8'hB4, 4'd3);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 2) begin start = 1'b1; data_in = 8'hFF; shift_in = 4'd1; end
            if (n == 3) start = 1'b0;
        end
        total_cnt++; if (n !== 7) $display("FAIL ignore_latency: got %0d expected 7", n); else pass_cnt++;
        total_cnt++; if (data_out !== 8'h16) $display("FAIL ignore_data: got %h expected 16", data_out); else pass_cnt++;
        total_cnt++; if (sticky !== STK) $display("FAIL ignore_sticky: got %b expected %b", sticky, STK); else pass_cnt++;
        // Start raised during S_DONE and held into the first idle cycle.
        data_in = 8'h80; shift_in = 4'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (rdy !== 1'b1 || data_out !== 8'h16) $display("FAIL b2b_done_ignored: got rdy %b data %h expected 1 16", rdy, data_out); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if (rdy !== 1'b0) $display("FAIL b2b_accept: got rdy %b expected 0", rdy); else pass_cnt++;
        wait_done(n);
        total_cnt++; if (n !== 5) $display("FAIL b2b_latency: got %0d expected 5", n); else pass_cnt++;
        total_cnt++; if (data_out !== 8'h20 || sticky !== 1'b0) $display("FAIL b2b_result: got %h/%b expected 20/0", data_out, sticky); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int n;
        int pulses;
        start_op(8'hFF, 4'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (data_out !== 8'h7F || sticky !== STK || rdy !== 1'b0) $display("FAIL midshift_pre: got %h/%b rdy %b expected 7f/%b 0", data_out, sticky, rdy, STK); else pass_cnt++;
        #2 rstb = 1'b0;
        #1;
        total_cnt++; if (rdy !== 1'b1 || data_out !== 8'h00 || sticky !== 1'b0 || done !== 1'b0) $display("FAIL midshift_reset: got rdy %b data %h sticky %b done %b expected 1 00 0 0", rdy, data_out, sticky, done); else pass_cnt++;
        pulses = 0;
        @(posedge clk);
        @(negedge clk);
        if (done) pulses++;
        // Release reset and request in the same cycle: first edge must accept.
        rstb = 1'b1; data_in = 8'h5A; shift_in = 4'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if (pulses !== 0) $display("FAIL midshift_no_done: got %0d pulses expected 0", pulses); else pass_cnt++;
        total_cnt++; if (rdy !== 1'b0) $display("FAIL first_accept: got rdy %b expected 0", rdy); else pass_cnt++;
        wait_done(n);
        total_cnt++; if (n !== 1 || data_out !== 8'h5A) $display("FAIL first_accept_result: got %0d/%h expected 1/5a", n, data_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_op("b4_s3", 8'hB4, 4'd3, 8'h16, 1'b1, 7);
        test_op("80_s2", 8'h80, 4'd2, 8'h20, 1'b0, 5);
        test_op("5a_s0", 8'h5A, 4'd0, 8'h5A, 1'b0, 1);
        test_op("01_s15", 8'h01, 4'd15, 8'h00, 1'b1, 3);
        test_op("80_s15", 8'h80, 4'd15, 8'h00, 1'b1, 17);
        test_op("00_s5", 8'h00, 4'd5, 8'h00, 1'b0, 1);
        test_ignore_and_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/denorm_unit.md
DENORM_UNIT -- requirements
Module: denorm_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8: mantissa register width.
REQ-002 SHALL have parameter CNT_W, default 4: shift-count register width.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-004 SHALL have port rstb, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request; accepted only while rdy=1.
REQ-006 SHALL have port data_in, input, DATA_W: mantissa; sampled on the accept edge.
REQ-007 SHALL have port shift_in, input, CNT_W: right-shift count; sampled on the accept edge.
REQ-008 SHALL have port rdy, output, 1: high only in S_IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high only in S_DONE.
REQ-010 SHALL have port data_out, output, DATA_W: mantissa register R1, driven directly.
REQ-011 SHALL have port sticky, output, 1: OR of all bits shifted out of R1.

Function
REQ-012 SHALL implement a four-state FSM: S_IDLE, S_CHECK, S_SHIFT, S_DONE.
REQ-013 S_IDLE with start=1 SHALL load R1<=data_in, R2<=shift_in and sticky<=0, then go to S_CHECK; with start=0 it SHALL stay in S_IDLE with registers held.
REQ-014 S_CHECK SHALL go to S_DONE if R2==0 or R1==0 (early exit); otherwise it SHALL go to S_SHIFT; registers are held.
REQ-015 S_SHIFT SHALL perform R1<=R1>>1 (zero fill), R2<=R2-1 and sticky<=sticky|R1[0], then go to S_CHECK.
REQ-016 S_DONE SHALL assert done for exactly one cycle, then go to S_IDLE unconditionally.
REQ-017 start outside S_IDLE SHALL be ignored; this includes start in S_DONE and start held high through an operation.
REQ-018 Latency: with accept edge E0 and k shifts actually performed, S_DONE SHALL occupy the cycle after edge E0+2k+1, and rdy SHALL return after edge E0+2k+2.
REQ-019 k SHALL equal min(shift_in, position of highest set bit of data_in + 1), and k=0 when data_in==0.
REQ-020 R2 SHALL never decrement below 0; a shift_in larger than DATA_W SHALL yield data_out=0 through the early exit, with no wrap-around.
REQ-021 data_out and sticky SHALL hold the result from S_DONE until the next accepted start.
REQ-022 Back-to-back: a start presented in the first S_IDLE cycle after S_DONE SHALL be accepted.

Reset
REQ-023 rstb=0 SHALL immediately force S_IDLE, R1=0, R2=0 and sticky=0, giving rdy=1, done=0 and data_out=0, regardless of clk.
REQ-024 Reset during any state, including mid-shift, SHALL abort the operation with no done pulse.
REQ-025 The first accept SHALL be possible on the first rising edge after rstb deasserts.

Configuration
REQ-026 Macro DENORM_STICKY_EN defined: SHALL build the sticky register and logic per REQ-013, REQ-015 and REQ-023.
REQ-027 Macro DENORM_STICKY_EN undefined: the sticky output SHALL be tied to 0, no sticky flop is instantiated, and all other behaviour and timing SHALL be identical.

Verification
REQ-028 data_in=8'hB4, shift_in=3 -> data_out=8'h16, sticky=1, done high after edge E0+7.
REQ-029 data_in=8'h80, shift_in=2 -> data_out=8'h20, sticky=0, done after edge E0+5.
REQ-030 data_in=8'h5A, shift_in=0 -> data_out=8'h5A, sticky=0, done after edge E0+1.
REQ-031 data_in=8'h01, shift_in=15 -> early exit, data_out=8'h00, sticky=1, done after edge E0+3.
REQ-032 During the REQ-028 operation, pulse start with data_in=8'hFF -> ignored, result unchanged; then start in the cycle after done -> accepted per REQ-022.
REQ-033 Assert rstb=0 while in S_SHIFT -> rdy=1, data_out=0, sticky=0 immediately, and no done pulse.
